// File: rtl/csr_print_master.sv
// CSR print channel initiator: queues valid print requests and replays each one
// to the print handler as an arm cycle (state=0) followed by an issue cycle (state=mode).
module csr_print_master #(
   parameter int unsigned DEPTH     = 8,
   parameter logic [31:0] IDLE_CODE = 32'hFFFF_FFFF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [2:0]               req_mode,
   input  logic [31:0]              req_value,
   output logic [31:0]              state_o,
   output logic [31:0]              value_o,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level,
   output logic [31:0]              sent_cnt,
   output logic [15:0]              err_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARM   = 2'd1;
   localparam logic [1:0] S_ISSUE = 2'd2;

   logic [1:0]    r_state;
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_count;
   logic [2:0]    r_mem_mode  [DEPTH];
   logic [31:0]   r_mem_value [DEPTH];
   logic [2:0]    r_cmd_mode;
   logic [31:0]   r_cmd_value;
   logic [31:0]   r_state_o;
   logic [31:0]   r_value_o;
   logic [31:0]   r_sent_cnt;
   logic [15:0]   r_err_cnt;

   logic          w_full;
   logic          w_empty;
   logic          w_take;
   logic          w_mode_ok;
   logic          w_push;
   logic          w_err;
   logic          w_pop;
   logic [1:0]    w_state_nxt;
   logic [31:0]   w_state_o_nxt;
   logic [31:0]   w_value_o_nxt;

   assign w_full    = (r_count == LW'(DEPTH));
   assign w_empty   = (r_count == '0);
   assign w_take    = req_valid && !w_full && rst_n;
   assign w_mode_ok = (req_mode >= 3'd1) && (req_mode <= 3'd5);
   assign w_push    = w_take && w_mode_ok;
   assign w_err     = w_take && !w_mode_ok;

   assign req_ready = !w_full;
   assign busy      = (r_state != S_IDLE) || !w_empty;
   assign level     = r_count;
   assign state_o   = r_state_o;
   assign value_o   = r_value_o;
   assign sent_cnt  = r_sent_cnt;
   assign err_cnt   = r_err_cnt;

   // Next state, pop decision and the bus value to register for the next cycle
   always_comb begin
      w_state_nxt   = r_state;
      w_pop         = 1'b0;
      w_state_o_nxt = IDLE_CODE;
      w_value_o_nxt = '0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_ARM;
            end
         end
         S_ARM: w_state_nxt = S_ISSUE;
         S_ISSUE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_ARM;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      case (w_state_nxt)
         S_ARM: begin
            w_state_o_nxt = '0;
            w_value_o_nxt = '0;
         end
         S_ISSUE: begin
            w_state_o_nxt = {29'b0, r_cmd_mode};
            w_value_o_nxt = r_cmd_value;
         end
         default: begin
            w_state_o_nxt = IDLE_CODE;
            w_value_o_nxt = '0;
         end
      endcase
   end

   // Storage array carries no reset; pointers and count define validity
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_mode[r_wr_ptr]  <= req_mode;
         r_mem_value[r_wr_ptr] <= req_value;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_cmd_mode  <= '0;
         r_cmd_value <= '0;
         r_state_o   <= IDLE_CODE;
         r_value_o   <= '0;
         r_sent_cnt  <= '0;
         r_err_cnt   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_state_o <= w_state_o_nxt;
         r_value_o <= w_value_o_nxt;
         r_count   <= r_count + LW'(w_push) - LW'(w_pop);
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr    <= r_rd_ptr + AW'(1);
            r_cmd_mode  <= r_mem_mode[r_rd_ptr];
            r_cmd_value <= r_mem_value[r_rd_ptr];
         end
         if (r_state == S_ISSUE) begin
            r_sent_cnt <= r_sent_cnt + 32'd1;
         end
         if (w_err && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_csr_print_master.sv
// Directed bench for csr_print_master: single, burst, full, invalid-mode,
// mid-command reset and push-with-pop counter-dump scenarios.
module tb_csr_print_master;

   localparam logic [31:0] IDLE = 32'hFFFF_FFFF;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_mode;
   logic [31:0] req_value;
   logic [31:0] state_o;
   logic [31:0] value_o;
   logic        busy;
   logic [3:0]  level;
   logic [31:0] sent_cnt;
   logic [15:0] err_cnt;

   int checks   = 0;
   int failures = 0;

   csr_print_master #(.DEPTH(8), .IDLE_CODE(32'hFFFF_FFFF)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_mode(req_mode), .req_value(req_value), .state_o(state_o), .value_o(value_o),
      .busy(busy), .level(level), .sent_cnt(sent_cnt), .err_cnt(err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b1; req_mode = 3'd0; req_value = 32'h1;
      @(negedge clk);
      checks++; if (state_o !== IDLE) begin failures++; $display("FAIL reset_state got=%h exp=%h", state_o, IDLE); end
      checks++; if (value_o !== 32'd0) begin failures++; $display("FAIL reset_value got=%h exp=0", value_o); end
      checks++; if (sent_cnt !== 32'd0) begin failures++; $display("FAIL reset_sent got=%0d exp=0", sent_cnt); end
      checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", err_cnt); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
      req_mode = 3'd1;
      @(negedge clk);
      checks++; if (level !== 4'd0) begin failures++; $display("FAIL reset_nopush got=%0d exp=0", level); end
      req_valid = 1'b0; rst_n = 1'b1;
   endtask

   task automatic test_single();
      do_reset();
      req_valid = 1'b1; req_mode = 3'd1; req_value = 32'd42;
      @(negedge clk); req_valid = 1'b0;
      checks++; if (level !== 4'd1) begin failures++; $display("FAIL single_level_k got=%0d exp=1", level); end
      checks++; if (state_o !== IDLE) begin failures++; $display("FAIL single_state_k got=%h exp=%h", state_o, IDLE); end
      @(negedge clk);
      checks++; if (state_o !== 32'd0) begin failures++; $display("FAIL single_arm got=%h exp=0", state_o); end
      checks++; if (level !== 4'd0) begin failures++; $display("FAIL single_level_pop got=%0d exp=0", level); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
      @(negedge clk);
      checks++; if (state_o !== 32'd1) begin failures++; $display("FAIL single_issue got=%h exp=1", state_o); end
      checks++; if (value_o !== 32'd42) begin failures++; $display("FAIL single_value got=%0d exp=42", value_o); end
      checks++; if (sent_cnt !== 32'd0) begin failures++; $display("FAIL single_sent_early got=%0d exp=0", sent_cnt); end
      @(negedge clk);
      checks++; if (state_o !== IDLE) begin failures++; $display("FAIL single_idle got=%h exp=%h", state_o, IDLE); end
      checks++; if (sent_cnt !== 32'd1) begin failures++; $display("FAIL single_sent got=%0d exp=1", sent_cnt); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", busy); end
   endtask

   task automatic test_burst();
      logic [31:0] vals   [3];
      logic [31:0] exp_s  [8];
      logic [31:0] exp_v  [8];
      logic [3:0]  exp_l  [8];
      int          peak;
      vals[0] = 32'h48; vals[1] = 32'h69; vals[2] = 32'h0A;
      exp_s[0] = IDLE;  exp_s[1] = 32'd0; exp_s[2] = 32'd2; exp_s[3] = 32'd0;
      exp_s[4] = 32'd2; exp_s[5] = 32'd0; exp_s[6] = 32'd2; exp_s[7] = IDLE;
      exp_v[0] = 32'd0; exp_v[1] = 32'd0; exp_v[2] = 32'h48; exp_v[3] = 32'd0;
      exp_v[4] = 32'h69; exp_v[5] = 32'd0; exp_v[6] = 32'h0A; exp_v[7] = 32'd0;
      exp_l[0] = 4'd1; exp_l[1] = 4'd1; exp_l[2] = 4'd2; exp_l[3] = 4'd1;
      exp_l[4] = 4'd1; exp_l[5] = 4'd0; exp_l[6] = 4'd0; exp_l[7] = 4'd0;
      peak = 0;
      do_reset();
      for (int t = 0; t < 8; t++) begin
         req_valid = (t < 3);
         req_mode  = 3'd2;
         req_value = (t < 3) ? vals[t] : 32'd0;
         @(negedge clk);
         if (int'(level) > peak) peak = int'(level);
         checks++; if (state_o !== exp_s[t]) begin failures++; $display("FAIL burst_state t=%0d got=%h exp=%h", t, state_o, exp_s[t]); end
         checks++; if (value_o !== exp_v[t]) begin failures++; $display("FAIL burst_value t=%0d got=%h exp=%h", t, value_o, exp_v[t]); end
         checks++; if (level !== exp_l[t]) begin failures++; $display("FAIL burst_level t=%0d got=%0d exp=%0d", t, level, exp_l[t]); end
      end
      req_valid = 1'b0;
      checks++; if (peak != 2) begin failures++; $display("FAIL burst_peak got=%0d exp=2", peak); end
      checks++; if (sent_cnt !== 32'd3) begin failures++; $display("FAIL burst_sent got=%0d exp=3", sent_cnt); end
   endtask

   // Continuous pushes outrun the 2-cycle drain: FIFO reaches 8 after 15 accepts
   task automatic test_full();
      int          el;
      logic [31:0] es;
      logic [31:0] ev;
      do_reset();
      for (int t = 0; t < 32; t++) begin
         req_valid = (t < 16);
         req_mode  = 3'd3;
         req_value = 32'h100 + 32'(t);
         @(negedge clk);
         if (t < 15) el = (t % 2 == 0) ? (t / 2 + 1) : ((t + 1) / 2);
         else        el = (7 - (t - 15) / 2 < 0) ? 0 : 7 - (t - 15) / 2;
         if (t == 0 || t == 31)   begin es = IDLE;  ev = 32'd0; end
         else if (t % 2 == 1)     begin es = 32'd0; ev = 32'd0; end
         else                     begin es = 32'd3; ev = 32'h100 + 32'((t - 2) / 2); end
         checks++; if (level !== 4'(el)) begin failures++; $display("FAIL full_level t=%0d got=%0d exp=%0d", t, level, el); end
         checks++; if (req_ready !== (el != 8)) begin failures++; $display("FAIL full_ready t=%0d got=%b exp=%b", t, req_ready, (el != 8)); end
         checks++; if (state_o !== es) begin failures++; $display("FAIL full_state t=%0d got=%h exp=%h", t, state_o, es); end
         checks++; if (value_o !== ev) begin failures++; $display("FAIL full_value t=%0d got=%h exp=%h", t, value_o, ev); end
      end
      req_valid = 1'b0;
      checks++; if (sent_cnt !== 32'd15) begin failures++; $display("FAIL full_sent got=%0d exp=15", sent_cnt); end
   endtask

   task automatic test_invalid();
      logic [2:0]  modes [4];
      logic [31:0] es;
      modes[0] = 3'd0; modes[1] = 3'd6; modes[2] = 3'd7; modes[3] = 3'd3;
      do_reset();
      for (int t = 0; t < 7; t++) begin
         req_valid = (t < 4);
         req_mode  = (t < 4) ? modes[t] : 3'd0;
         req_value = 32'hDEAD_BEEF;
         @(negedge clk);
         es = (t == 4) ? 32'd0 : (t == 5) ? 32'd3 : IDLE;
         checks++; if (state_o !== es) begin failures++; $display("FAIL inv_state t=%0d got=%h exp=%h", t, state_o, es); end
         checks++; if (err_cnt !== 16'((t < 3) ? t + 1 : 3)) begin failures++; $display("FAIL inv_err t=%0d got=%0d exp=%0d", t, err_cnt, (t < 3) ? t + 1 : 3); end
         if (t == 5) begin
            checks++; if (value_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL inv_value got=%h exp=deadbeef", value_o); end
         end
      end
      req_valid = 1'b0;
      checks++; if (sent_cnt !== 32'd1) begin failures++; $display("FAIL inv_sent got=%0d exp=1", sent_cnt); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 7; i++) begin
         req_valid = 1'b1; req_mode = 3'd4; req_value = 32'h40 + 32'(i);
         @(negedge clk);
      end
      checks++; if (state_o !== 32'd4) begin failures++; $display("FAIL rmid_pre_state got=%h exp=4", state_o); end
      checks++; if (value_o !== 32'h42) begin failures++; $display("FAIL rmid_pre_value got=%h exp=42", value_o); end
      checks++; if (level !== 4'd4) begin failures++; $display("FAIL rmid_pre_level got=%0d exp=4", level); end
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (state_o !== IDLE) begin failures++; $display("FAIL rmid_state got=%h exp=%h", state_o, IDLE); end
      checks++; if (level !== 4'd0) begin failures++; $display("FAIL rmid_level got=%0d exp=0", level); end
      checks++; if (sent_cnt !== 32'd0) begin failures++; $display("FAIL rmid_sent got=%0d exp=0", sent_cnt); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
      req_mode = 3'd0;
      @(negedge clk);
      checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL rmid_err got=%0d exp=0", err_cnt); end
      rst_n = 1'b1; req_valid = 1'b0;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         checks++; if (state_o !== IDLE || busy !== 1'b0) begin failures++; $display("FAIL rmid_quiet t=%0d state=%h busy=%b exp=%h/0", t, state_o, busy, IDLE); end
      end
      req_valid = 1'b1; req_mode = 3'd2; req_value = 32'h5A;
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (state_o !== 32'd2 || value_o !== 32'h5A) begin failures++; $display("FAIL rmid_new state=%h value=%h exp=2/5a", state_o, value_o); end
      @(negedge clk);
      checks++; if (sent_cnt !== 32'd1) begin failures++; $display("FAIL rmid_new_sent got=%0d exp=1", sent_cnt); end
   endtask

   task automatic test_counter_dump();
      do_reset();
      req_valid = 1'b1; req_mode = 3'd1; req_value = 32'd7;
      @(negedge clk);
      checks++; if (level !== 4'd1) begin failures++; $display("FAIL dump_level_k got=%0d exp=1", level); end
      req_mode = 3'd5; req_value = 32'd0;
      @(negedge clk); req_valid = 1'b0;
      checks++; if (level !== 4'd1) begin failures++; $display("FAIL dump_level_pushpop got=%0d exp=1", level); end
      checks++; if (state_o !== 32'd0) begin failures++; $display("FAIL dump_arm1 got=%h exp=0", state_o); end
      @(negedge clk);
      checks++; if (state_o !== 32'd1 || value_o !== 32'd7) begin failures++; $display("FAIL dump_issue1 state=%h value=%h exp=1/7", state_o, value_o); end
      @(negedge clk);
      checks++; if (state_o !== 32'd0 || level !== 4'd0) begin failures++; $display("FAIL dump_arm2 state=%h level=%0d exp=0/0", state_o, level); end
      @(negedge clk);
      checks++; if (state_o !== 32'd5 || value_o !== 32'd0) begin failures++; $display("FAIL dump_issue5 state=%h value=%h exp=5/0", state_o, value_o); end
      @(negedge clk);
      checks++; if (state_o !== IDLE) begin failures++; $display("FAIL dump_idle got=%h exp=%h", state_o, IDLE); end
      checks++; if (sent_cnt !== 32'd2) begin failures++; $display("FAIL dump_sent got=%0d exp=2", sent_cnt); end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_mode = 3'd0; req_value = 32'd0;
      @(negedge clk);
      test_reset();
      test_single();
      test_burst();
      test_full();
      test_invalid();
      test_reset_mid();
      test_counter_dump();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
